// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply, restoring divide,
// one bit per cycle, with flush cancellation and a pipeline stall request.
module muldiv_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    input  logic         mthi_we,
    input  logic         mtlo_we,
    input  logic [W-1:0] wdata,
    input  logic         hilo_rd,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         stall
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state, next_state;
    logic           is_div, neg_res, neg_rem, div_zero;
    logic [W-1:0]   opnd, acc, mq;
    logic [CW-1:0]  cnt;

    logic           load, step, finish;
    logic           sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_sum, div_shift;
    logic           qbit;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; flush wins over every transition out of a busy state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !flush) next_state = RUN;
            RUN:     if (flush) next_state = IDLE;
                     else if (cnt == CW'(W - 1)) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control strobes and the combinational stall request
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    load   = start & ~flush;
            RUN:     step   = ~flush;
            FIN:     finish = ~flush;
            default: ;
        endcase
        stall = busy & (hilo_rd | start | mthi_we | mtlo_we) & ~flush;
    end

    // Operand magnitudes, one iteration of each algorithm, and result sign fix-up
    always_comb begin
        sa        = ~op[0] & a[W-1];
        sb        = ~op[0] & b[W-1];
        abs_a     = sa ? -a : a;
        abs_b     = sb ? -b : b;
        mul_sum   = {1'b0, acc} + ({1'b0, opnd} & {(W+1){mq[0]}});
        div_shift = {acc, mq[W-1]};
        qbit      = (div_shift >= {1'b0, opnd});
        div_rem   = qbit ? W'(div_shift - {1'b0, opnd}) : W'(div_shift);
        prod_fix  = neg_res ? -{acc, mq} : {acc, mq};
        quo_fix   = div_zero ? '1 : (neg_res ? -mq : mq);
        rem_fix   = neg_rem ? -acc : acc;
    end

    // Working registers: opnd is the addend (multiply) or divisor (divide);
    // mq holds multiplier/product-low or dividend/quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            mq       <= '0;
            cnt      <= '0;
        end else if (load) begin
            is_div   <= op[1];
            neg_res  <= sa ^ sb;
            neg_rem  <= sa;
            div_zero <= op[1] & (b == '0);
            opnd     <= op[1] ? abs_b : abs_a;
            mq       <= op[1] ? abs_a : abs_b;
            acc      <= '0;
            cnt      <= '0;
        end else if (step) begin
            if (is_div) begin
                acc <= div_rem;
                mq  <= {mq[W-2:0], qbit};
            end else begin
                acc <= mul_sum[W:1];
                mq  <= {mul_sum[0], mq[W-1:1]};
            end
            cnt <= cnt + CW'(1);
        end
    end

    // HI/LO: completion or MTHI/MTLO in IDLE only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= is_div ? rem_fix : prod_fix[2*W-1:W];
            lo <= is_div ? quo_fix : prod_fix[W-1:0];
        end else if (state == IDLE) begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b0;
        else        busy <= (next_state != IDLE);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam int LAT = 33;

    logic          clk, rst_n, start, flush, mthi_we, mtlo_we, hilo_rd;
    logic [1:0]    op;
    logic [W-1:0]  a, b, wdata, hi, lo;
    logic          busy, stall;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .hilo_rd(hilo_rd), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition of each op
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint       p;
        logic [31:0]  q, r;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return 64'(p);
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = 32'($signed(x) / $signed(y));
                r = 32'($signed(x) % $signed(y));
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the start edge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Counts remaining busy cycles, optionally checks the stall request, then checks HI/LO
    task automatic finish_op(input string tag, input logic [63:0] exp, input int exp_cycles, input bit rd);
        int n;
        int st;
        n  = 0;
        st = 0;
        hilo_rd = rd;
        while (busy && n < 100) begin
            n++;
            #1;
            if (stall) st++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_cycles));
        if (rd) begin
            check({tag, " stall_cycles"}, 64'(st), 64'(n));
            #1;
            check({tag, " stall_after"}, 64'(stall), 64'(0));
        end
        check({tag, " hilo"}, {hi, lo}, exp);
        hilo_rd = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit rd);
        issue(o, x, y);
        finish_op(tag, model(o, x, y), LAT, rd);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        hilo_rd = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset hilo", {hi, lo}, 64'h0);
        check("reset busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu", 2'b11, 32'd100, 32'd7, 1'b0);
        check("divu const", {hi, lo}, {32'd2, 32'd14});
        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0);
        check("divu_zero const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        run("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);

        // Second start while busy is ignored and raises stall
        issue(2'b01, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
        #1 check("start_busy stall", 64'(stall), 64'(1));
        @(negedge clk);
        start = 1'b0;
        finish_op("start_busy", {32'h0, 32'd42}, LAT - 4, 1'b1);

        // MTLO together with start: write lands, completion overwrites later
        mtlo_we = 1'b1; wdata = 32'h0000_ABCD;
        issue(2'b01, 32'd3, 32'd4);
        mtlo_we = 1'b0;
        check("mt_start lo", 64'(lo), 64'h0000_ABCD);
        finish_op("mt_start", {32'h0, 32'd12}, LAT, 1'b0);

        // MT writes in IDLE, MTHI ignored while busy, flush mid-RUN
        mthi_we = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mtlo_we = 1'b0;
        check("mt_idle hilo", {hi, lo}, 64'h0000_5678_0000_1234);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        mthi_we = 1'b1; wdata = 32'h0000_DEAD;
        #1 check("mthi_busy stall", 64'(stall), 64'(1));
        @(negedge clk);
        mthi_we = 1'b0;
        check("mthi_busy ignored", 64'(hi), 64'h0000_5678);
        repeat (3) @(negedge clk);
        hilo_rd = 1'b1; flush = 1'b1;
        #1 check("flush stall", 64'(stall), 64'(0));
        @(negedge clk);
        flush = 1'b0; hilo_rd = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("flush hilo", {hi, lo}, 64'h0000_5678_0000_1234);

        // Flush with start in IDLE: start dropped
        flush = 1'b1;
        issue(2'b01, 32'd2, 32'd2);
        flush = 1'b0;
        check("flush_start busy", 64'(busy), 64'(0));
        check("flush_start hilo", {hi, lo}, 64'h0000_5678_0000_1234);

        // Flush in FIN: no result written
        issue(2'b01, 32'd9, 32'd9);
        repeat (32) @(negedge clk);
        check("fin busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fin_flush busy", 64'(busy), 64'(0));
        check("fin_flush hilo", {hi, lo}, 64'h0000_5678_0000_1234);

        // Asynchronous reset mid-RUN, then a fresh op is accepted
        issue(2'b11, 32'd1000, 32'd9);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst hilo", {hi, lo}, 64'h0);
        check("async_rst busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 2'b11, 32'd100, 32'd7, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = pick();
            ry = pick();
            run($sformatf("rand%0d op%0d %h/%h", i, ro, rx, ry), ro, rx, ry, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
